serial_subtractor: RTL and testbench
====================================

# serial_subtractor

Bit-serial two's-complement subtractor computing `diff = a - b` one bit per clock, LSB first, through a single full-subtractor cell and a borrow flip-flop. It is the inverse-direction companion to the team's ripple full-adder datapath. It serves area-constrained control paths where multi-cycle latency is acceptable. Operands enter and results leave over valid/ready handshakes.

## Interface
- `WIDTH`, default 8: operand and result width in bits; legal range ≥ 2.
- `clk`  in  1  rising-edge clock; the only clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  operands present on `a`/`b`.
- `in_ready`  out  1  block can accept operands.
- `a`  in  WIDTH  minuend.
- `b`  in  WIDTH  subtrahend.
- `out_valid`  out  1  result fields valid.
- `out_ready`  in  1  consumer accepts result.
- `diff`  out  WIDTH  `a - b` modulo 2^WIDTH.
- `bout`  out  1  final borrow; 1 iff unsigned `a < b`.
- `ovf`  out  1  signed overflow.
- `zero`  out  1  `diff == 0`.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- **IDLE**
  - `in_ready=1`, `out_valid=0`.
  - When `in_valid` is sampled high: latch `a` and `b` into shift registers, and record `a[WIDTH-1]` and `b[WIDTH-1]`.
  - Clear borrow and `zero` accumulator; set bit counter to 0; go to SHIFT.
- **SHIFT**
  - `in_ready=0`; `in_valid` is ignored.
  - Each cycle, with a0, b0 the register LSBs and br the borrow flip-flop:
    - d = a0 ^ b0 ^ br.
    - br_next = (~a0 & b0) | (~(a0 ^ b0) & br).
  - Shift d into the result MSB and shift the operand registers right.
  - OR d into the nonzero accumulator; increment the counter.
  - After the WIDTH-th bit, go to DONE.
- **DONE**
  - `out_valid=1`; `diff`, `bout`, `ovf`, `zero` held stable.
  - Go to IDLE on the cycle `out_ready` is sampled high; otherwise stay indefinitely.
- **Result fields**
  - `bout` = final br.
  - `ovf` = (a_msb != b_msb) & (diff[WIDTH-1] != a_msb).
  - `zero` = ~accumulator.
- **Arithmetic:** all results are modulo 2^WIDTH. No saturation. No sign extension.
- **Reset**
  - Values: `in_ready=0`, `out_valid=0`, `diff=0`, `bout=0`, `ovf=0`, `zero=0`, state IDLE, counter 0.
  - `in_ready` rises on the first cycle after `rst_n` deasserts.
- **Reset mid-operation** (SHIFT or DONE): discard the operation and all partial results. Outputs return to reset values on the next edge.
- Result fields outside DONE read 0.

## Timing
- Accept edge T0: edge where `in_valid & in_ready` is sampled.
- SHIFT occupies edges T1..TWIDTH; `out_valid` is high from the cycle after TWIDTH.
- Latency: WIDTH+1 cycles from the accepting cycle to the first `out_valid` cycle.
- `out_ready` held high in DONE: result transfers that cycle, IDLE next cycle.
- Minimum initiation interval: WIDTH+2 cycles. No overlap of operations; `in_ready` is low in SHIFT and DONE.
- `out_ready` asserted outside DONE has no effect.
- Both handshakes are registered; no combinational path from `in_valid` or `out_ready` to any output.

## Structure
- Shared package `arith_pkg`:
  - FSM state typedef (IDLE, SHIFT, DONE; 2-bit encoding).
  - Function `clog2`-based counter width for WIDTH.
- One natural sub-module, `full_subtractor`: combinational cell with inputs `in1`, `in2`, `bin` and outputs `d`, `bout`, implementing the equations above.
  - Instantiated once in the serial datapath.
  - Reused by future ripple subtractors.
- The top level holds the FSM, counter, shift registers, borrow flip-flop and flag logic.

## Test plan
All scenarios use WIDTH=8.
- `a=0x05, b=0x03` → `diff=0x02`, `bout=0`, `ovf=0`, `zero=0`; `out_valid` exactly 9 cycles after the accepting cycle.
- `a=0x03, b=0x05` → `diff=0xFE`, `bout=1`, `ovf=0`; `a=0x80, b=0x01` → `diff=0x7F`, `ovf=1`, `bout=0`.
- `a=0x5A, b=0x5A` → `diff=0x00`, `zero=1`, `bout=0`; then `a=0x00, b=0xFF` → `diff=0x01`, `bout=1`, `ovf=0`.
- Backpressure:
  - Hold `out_ready=0` for 5 cycles in DONE: all outputs stable and `in_ready=0` throughout.
  - Pulse `in_valid` with new operands during SHIFT: ignored; the first result is unchanged.
- Reset mid-SHIFT: assert `rst_n=0` at the 4th SHIFT cycle → all outputs 0 next edge; `in_ready=1` one cycle after release.
  - A fresh `0x10-0x01` afterwards yields `0x0F`.
- Back-to-back:
  - `out_ready` tied high, `in_valid` tied high → accepts every 10 cycles.
  - 100 random operand pairs match a `(a-b) mod 256` reference model, including `bout`, `ovf` and `zero`.

Source files
------------

// File: rtl/arith_pkg.sv
// Shared arithmetic definitions: FSM state encoding and counter sizing helper
// used by the bit-serial datapaths.
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Ceiling log2, at least 1 so a counter always has one bit.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// Combinational one-bit full-subtractor cell: d = in1 - in2 - bin.
module full_subtractor (
  input  logic in1,
  input  logic in2,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = in1 ^ in2 ^ bin;
  assign bout = (~in1 & in2) | (~(in1 ^ in2) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, through one full-subtractor cell and a borrow
// flip-flop, with valid/ready handshakes on both sides and registered outputs.
module serial_subtractor
  import arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);

  localparam int CW = clog2(WIDTH);

  state_t           state_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-2:0] res_reg;
  logic [CW-1:0]    cnt_reg;
  logic             br_reg;
  logic             acc_reg;
  logic             a_msb_reg;
  logic             b_msb_reg;

  logic             d_bit;
  logic             br_next;
  logic [WIDTH-1:0] diff_next;

  full_subtractor u_fs (
    .in1  (a_reg[0]),
    .in2  (b_reg[0]),
    .bin  (br_reg),
    .d    (d_bit),
    .bout (br_next)
  );

  // Partial result with the current bit shifted into the MSB.
  assign diff_next = {d_bit, res_reg};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      res_reg   <= '0;
      cnt_reg   <= '0;
      br_reg    <= 1'b0;
      acc_reg   <= 1'b0;
      a_msb_reg <= 1'b0;
      b_msb_reg <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      diff      <= '0;
      bout      <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_reg     <= a;
            b_reg     <= b;
            a_msb_reg <= a[WIDTH-1];
            b_msb_reg <= b[WIDTH-1];
            res_reg   <= '0;
            br_reg    <= 1'b0;
            acc_reg   <= 1'b0;
            cnt_reg   <= '0;
            in_ready  <= 1'b0;
            state_reg <= SHIFT;
          end else begin
            in_ready  <= 1'b1;
          end
        end
        SHIFT: begin
          a_reg   <= a_reg >> 1;
          b_reg   <= b_reg >> 1;
          res_reg <= diff_next[WIDTH-1:1];
          br_reg  <= br_next;
          acc_reg <= acc_reg | d_bit;
          cnt_reg <= cnt_reg + CW'(1);
          if (cnt_reg == CW'(WIDTH - 1)) begin
            // Last bit: publish the complete result directly from the cell.
            state_reg <= DONE;
            out_valid <= 1'b1;
            diff      <= diff_next;
            bout      <= br_next;
            ovf       <= (a_msb_reg ^ b_msb_reg) & (d_bit ^ a_msb_reg);
            zero      <= ~(acc_reg | d_bit);
          end
        end
        DONE: begin
          if (out_ready) begin
            state_reg <= IDLE;
            out_valid <= 1'b0;
            diff      <= '0;
            bout      <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
            cnt_reg   <= '0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=8): directed corner cases,
// backpressure, mid-operation reset and back-to-back random traffic.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] diff;
  logic       bout;
  logic       ovf;
  logic       zero;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .ovf       (ovf),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] ia;
    logic [7:0] ib;
    logic [7:0] d;
    logic       bo;
    logic       ov;
    logic       z;
    int         acc;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_acc = -1;
  bit   b2b_mode = 1'b0;
  logic pv = 1'b0;
  logic pr = 1'b0;
  logic [10:0] pfields = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference: plain integer arithmetic on the operands.
  function automatic exp_t model(input logic [7:0] x, input logic [7:0] y, input int acc_cyc);
    exp_t e;
    int sx, sy, sd;
    sx = $signed(x);
    sy = $signed(y);
    sd = sx - sy;
    e.ia  = x;
    e.ib  = y;
    e.d   = 8'((int'(x) - int'(y)) & 255);
    e.bo  = (int'(x) < int'(y));
    e.ov  = (sd > 127) || (sd < -128);
    e.z   = (e.d == 8'h00);
    e.acc = acc_cyc;
    return e;
  endfunction

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      sbq.delete();
      pv = 1'b0;
      pr = 1'b0;
      last_acc = -1;
    end else begin
      if (in_valid && in_ready) begin
        sbq.push_back(model(a, b, cyc));
        if (b2b_mode && last_acc >= 0) chk("initiation_interval", cyc - last_acc, 10);
        last_acc = cyc;
      end
      if (pv && !pr) begin
        chk("hold_valid", out_valid, 1'b1);
        chk("hold_fields", {diff, bout, ovf, zero}, pfields);
        chk("hold_in_ready", in_ready, 1'b0);
      end
      if (!out_valid) begin
        chk("fields_zero_outside_done", {diff, bout, ovf, zero}, 11'h0);
      end else if (sbq.size() == 0) begin
        chk("unexpected_out_valid", out_valid, 1'b0);
      end else begin
        chk("no_overlap_in_ready", in_ready, 1'b0);
        if (!pv) chk("latency", cyc - sbq[0].acc, 9);
        if (out_ready) begin
          exp_t e;
          e = sbq.pop_front();
          $display("txn a=%02h b=%02h -> diff=%02h bout=%0b ovf=%0b zero=%0b (exp %02h %0b %0b %0b)",
                   e.ia, e.ib, diff, bout, ovf, zero, e.d, e.bo, e.ov, e.z);
          chk("diff", diff, e.d);
          chk("bout", bout, e.bo);
          chk("ovf", ovf, e.ov);
          chk("zero", zero, e.z);
        end
      end
      pv = out_valid;
      pr = out_ready;
      pfields = {diff, bout, ovf, zero};
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    if (!in_ready) chk("wait_in_ready_timeout", in_ready, 1'b1);
  endtask

  task automatic send(input logic [7:0] x, input logic [7:0] y);
    wait_ready();
    in_valid = 1'b1;
    a = x;
    b = y;
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sbq.size() != 0 || out_valid) && n < 100) begin
      step();
      n++;
    end
    if (sbq.size() != 0) chk("drain_timeout", sbq.size(), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst_n = 1'b0;
    repeat (3) step();
    chk("reset_outputs", {in_ready, out_valid, diff, bout, ovf, zero}, 13'h0);
    rst_n = 1'b1;
    chk("in_ready_before_first_edge", in_ready, 1'b0);
    step();
    chk("in_ready_after_release", in_ready, 1'b1);

    // Directed corner cases.
    send(8'h05, 8'h03);
    send(8'h03, 8'h05);
    send(8'h80, 8'h01);
    send(8'h5A, 8'h5A);
    send(8'h00, 8'hFF);
    send(8'h7F, 8'hFF);
    send(8'hFF, 8'h00);
    drain();

    // Backpressure: hold the result for 5 cycles in DONE.
    out_ready = 1'b0;
    send(8'h37, 8'h62);
    n = 0;
    while (!out_valid && n < 50) begin
      step();
      n++;
    end
    chk("backpressure_reached_done", out_valid, 1'b1);
    repeat (5) step();
    out_ready = 1'b1;
    drain();

    // New operands during SHIFT must be ignored.
    send(8'h44, 8'h11);
    step();
    step();
    in_valid = 1'b1;
    a = 8'h99;
    b = 8'h22;
    step();
    in_valid = 1'b0;
    drain();

    // Reset during the 4th SHIFT cycle.
    send(8'hC3, 8'h2D);
    step();
    step();
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("midreset_outputs", {in_ready, out_valid, diff, bout, ovf, zero}, 13'h0);
    step();
    chk("midreset_in_ready_release", in_ready, 1'b1);
    send(8'h10, 8'h01);
    drain();

    // Back-to-back random traffic with in_valid and out_ready tied high.
    b2b_mode = 1'b1;
    last_acc = -1;
    in_valid = 1'b1;
    a = 8'($urandom_range(0, 255));
    b = 8'($urandom_range(0, 255));
    for (int i = 0; i < 100; i++) begin
      wait_ready();
      step();
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
    end
    in_valid = 1'b0;
    drain();
    b2b_mode = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
